mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single multi-cycle main memory between I-cache and D-cache miss handling.
//  Grants one requester at a time and sequences an 8-word block fill (issue/return counters).
//  Passes D-side write-through stores as single-cycle writes.
//  busy drives the pipeline stall logic alongside hazDetect.
// PARAMETERS
//  ADDR_W   16  byte address width
//  DATA_W   16  word width
//  BLK_WORDS 8  words per cache block (word offset = addr[3:1])
//  MEM_LAT   4  cycles from mem_enable (read) to mem_data_valid; memory accepts one read per cycle
// PORTS
//  clk            in   1   clock (single clock domain)
//  rst            in   1   synchronous, active-high reset
//  ic_req         in   1   I-cache miss; level, held until ic_done
//  ic_addr        in  16   I-cache miss byte address
//  dc_req         in   1   D-cache miss; level, held until dc_done
//  dc_addr        in  16   D-cache miss byte address
//  dc_wr_req      in   1   write-through store; held until dc_wr_ack
//  dc_wr_addr     in  16   store byte address
//  dc_wr_data     in  16   store data
//  mem_data_out   in  16   memory read data
//  mem_data_valid in   1   memory read data valid
//  mem_addr       out 16   memory address
//  mem_enable     out  1   memory access strobe
//  mem_wr         out  1   memory write (with mem_enable)
//  mem_data_in    out 16   memory write data
//  fill_data      out 16   returned word (shared by both caches)
//  ic_fill_valid  out  1   fill_data is for I-cache, word index fill_idx
//  dc_fill_valid  out  1   fill_data is for D-cache, word index fill_idx
//  fill_idx       out  3   word index within block
//  ic_done        out  1   1-cycle pulse, I fill complete
//  dc_done        out  1   1-cycle pulse, D fill complete
//  dc_wr_ack      out  1   1-cycle pulse, store accepted
//  busy           out  1   state != IDLE or a request is pending
// BEHAVIOUR
//  Reset: all outputs 0, state DRAIN, counters 0, last_grant = D.
//  States: DRAIN, IDLE, WRITE, ISSUE, WAIT, DONE.
//  DRAIN: hold MEM_LAT cycles after reset, ignoring mem_data_valid, so in-flight returns are discarded; then IDLE.
//  IDLE arbitration, sampled at clock edge:
//   - dc_wr_req wins always -> WRITE.
//   - Else if exactly one of dc_req/ic_req -> ISSUE for it.
//   - Both -> grant the side opposite last_grant, then update last_grant.
//  WRITE: exactly one cycle: mem_enable=1, mem_wr=1, mem_addr=dc_wr_addr, mem_data_in=dc_wr_data, dc_wr_ack=1; -> IDLE.
//  ISSUE:
//   - base = addr & ~16'h000F (addr latched at grant).
//   - Issue count i = 0..7: mem_enable=1, mem_wr=0, mem_addr=base+2*i, one per cycle.
//   - After i=7 -> WAIT.
//  Return: each mem_data_valid in ISSUE/WAIT:
//   - fill_data=mem_data_out, the granted side's fill_valid=1, fill_idx=return count; return count increments.
//   - Same-cycle issue and return both legal.
//  8th return: granted side's done=1 in that same cycle -> DONE.
//  DONE: one dead cycle; requests ignored so a stale held req is not regranted -> IDLE.
//  Fill latency (grant edge T0, MEM_LAT=4): issues T1..T8, returns T5..T12, done at T12, IDLE at T14.
//  mem_data_valid in IDLE/WRITE/DONE: ignored, no fill_valid.
//  Address math wraps modulo 2^16; base alignment guarantees no carry out of the block.
//  Requests changing while not granted: no effect; the granted addr is latched and changes are ignored.
//  rst asserted mid-fill: next cycle all outputs 0, state DRAIN; no done pulse is ever emitted for the aborted fill.
//  Never more than one of ic_fill_valid/dc_fill_valid/dc_wr_ack high.
// STRUCTURE
//  Package mem_arb_pkg holds:
//   - state encoding (3-bit enum)
//   - constants: BLK_WORDS, MEM_LAT, IDX_W=3, OFFS_MASK=16'h000F
//   - grant id enum (GNT_I, GNT_D)
//  Sub-module mem_fill_seq holds the issue counter, return counter and drain counter, with start/last_issue/last_return flags.
//  The arbiter FSM is the top level.
// TESTING
//  - dc_req, dc_addr=16'h1236 -> mem_addr 1230,1232,...,123E on T1..T8; dc_fill_valid idx 0..7 T5..T12; dc_done at T12.
//  - ic_req and dc_req raised same cycle after reset -> I granted first (last_grant=D); D granted after I done + DONE cycle.
//  - dc_wr_req raised during an I fill -> waits; in IDLE beats the pending ic_req; one-cycle mem_wr, dc_wr_ack, then I fill.
//  - addr 16'hFFFE fill -> mem_addr FFF0..FFFE, no wrap to 0000; idx 7 carries mem word at FFFE.
//  - rst at return 3 of a fill -> outputs 0 next cycle; stale valids for MEM_LAT cycles give no fill_valid; new req served cleanly.
//  - Spurious mem_data_valid in IDLE -> no fill_valid, no counter change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the main-memory arbiter
// Purpose: state encoding, grant identifiers, block geometry and memory latency
//          used by mem_arbiter and mem_fill_seq.
// Ports:   none (package).
package mem_arb_pkg;

   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;
   localparam int BLK_WORDS = 8;
   localparam int MEM_LAT   = 4;
   localparam int IDX_W     = 3;
   localparam int DRAIN_W   = $clog2(MEM_LAT + 1);

   localparam logic [ADDR_W-1:0] OFFS_MASK = 16'h000F;

   typedef enum logic [2:0] {
      ST_DRAIN = 3'd0,
      ST_IDLE  = 3'd1,
      ST_WRITE = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DONE  = 3'd5
   } arb_state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_e;

   // Block-aligned base of a byte address; word offsets are then ORed/added
   // without ever carrying out of the block.
   function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] addr);
      return addr & ~OFFS_MASK;
   endfunction

endpackage

// File: rtl/mem_fill_seq.sv
// rtl/mem_fill_seq.sv - issue/return/drain counters for block fills
// Purpose: counts read issues and data returns of one 8-word block fill and
//          the post-reset drain interval.
// Ports:   clk, rst        clock, synchronous active-high reset
//          start           clear issue/return counters (grant cycle)
//          issue, ret      advance issue / return counter
//          drain_en        drain counter runs while high, clears otherwise
//          issue_cnt       current issue word index
//          ret_cnt         current return word index
//          last_issue      issue_cnt is the final word of the block
//          last_return     ret_cnt is the final word of the block
//          drain_done      drain interval has elapsed
module mem_fill_seq
   import mem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             issue,
   input  logic             ret,
   input  logic             drain_en,
   output logic [IDX_W-1:0] issue_cnt,
   output logic [IDX_W-1:0] ret_cnt,
   output logic             last_issue,
   output logic             last_return,
   output logic             drain_done
);

   logic [DRAIN_W-1:0] drain_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt <= '0;
         ret_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         if (start) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
         end else begin
            if (issue)
               issue_cnt <= issue_cnt + IDX_W'(1);
            if (ret)
               ret_cnt <= ret_cnt + IDX_W'(1);
         end
         if (drain_en)
            drain_cnt <= drain_cnt + DRAIN_W'(1);
         else
            drain_cnt <= '0;
      end
   end

   assign last_issue  = (issue_cnt == IDX_W'(BLK_WORDS - 1));
   assign last_return = (ret_cnt   == IDX_W'(BLK_WORDS - 1));
   // Counter starts at 0 in the first drain cycle, so MEM_LAT cycles elapse.
   assign drain_done  = (drain_cnt == DRAIN_W'(MEM_LAT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache main-memory arbiter with block-fill sequencing
// Purpose: grants main memory to I-cache or D-cache misses (round robin when
//          both), sequences 8-word block fills and passes D-side write-through
//          stores as single-cycle writes.
// Ports:   clk, rst                      clock, synchronous active-high reset
//          ic_req/ic_addr                I-cache miss request and byte address
//          dc_req/dc_addr                D-cache miss request and byte address
//          dc_wr_req/dc_wr_addr/dc_wr_data  write-through store
//          mem_data_out/mem_data_valid   memory read return
//          mem_addr/mem_enable/mem_wr/mem_data_in  memory command
//          fill_data/fill_idx            returned word and its block index
//          ic_fill_valid/dc_fill_valid   fill word destination
//          ic_done/dc_done/dc_wr_ack     completion pulses
//          busy                          stall indication to the pipeline
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   input  logic              dc_req,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic              dc_wr_req,
   input  logic [ADDR_W-1:0] dc_wr_addr,
   input  logic [DATA_W-1:0] dc_wr_data,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic              mem_data_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic [DATA_W-1:0] fill_data,
   output logic              ic_fill_valid,
   output logic              dc_fill_valid,
   output logic [IDX_W-1:0]  fill_idx,
   output logic              ic_done,
   output logic              dc_done,
   output logic              dc_wr_ack,
   output logic              busy
);

   arb_state_e        state_q, state_d;
   grant_e            last_grant_q, gnt_q, grant_sel;
   logic [ADDR_W-1:0] base_q;

   logic              grant_fill;
   logic              ret_ok;
   logic              in_issue, in_drain;
   logic [IDX_W-1:0]  issue_cnt, ret_cnt;
   logic              last_issue, last_return, drain_done;

   assign in_issue = (state_q == ST_ISSUE);
   assign in_drain = (state_q == ST_DRAIN);

   // Stores always win in IDLE, so a fill is granted only without a pending store.
   assign grant_fill = (state_q == ST_IDLE) && !dc_wr_req && (ic_req || dc_req);

   // D wins when alone, or when both request and I was granted last.
   assign grant_sel = (dc_req && (!ic_req || last_grant_q == GNT_I)) ? GNT_D : GNT_I;

   // Returns count only while a fill is in flight; anything else is stale.
   assign ret_ok = mem_data_valid && (state_q == ST_ISSUE || state_q == ST_WAIT);

   mem_fill_seq u_fill_seq (
      .clk         (clk),
      .rst         (rst),
      .start       (grant_fill),
      .issue       (in_issue),
      .ret         (ret_ok),
      .drain_en    (in_drain),
      .issue_cnt   (issue_cnt),
      .ret_cnt     (ret_cnt),
      .last_issue  (last_issue),
      .last_return (last_return),
      .drain_done  (drain_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_DRAIN;
      else
         state_q <= state_d;
   end

   // Grant side and latched block base
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= GNT_D;
         gnt_q        <= GNT_D;
         base_q       <= '0;
      end else if (grant_fill) begin
         last_grant_q <= grant_sel;
         gnt_q        <= grant_sel;
         base_q       <= blk_base((grant_sel == GNT_D) ? dc_addr : ic_addr);
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_DRAIN: if (drain_done) state_d = ST_IDLE;
         ST_IDLE: begin
            if (dc_wr_req)
               state_d = ST_WRITE;
            else if (ic_req || dc_req)
               state_d = ST_ISSUE;
         end
         ST_WRITE: state_d = ST_IDLE;
         ST_ISSUE: begin
            if (ret_ok && last_return)
               state_d = ST_DONE;
            else if (last_issue)
               state_d = ST_WAIT;
         end
         ST_WAIT:  if (ret_ok && last_return) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_DRAIN;
      endcase
   end

   // Output logic
   always_comb begin
      mem_enable    = 1'b0;
      mem_wr        = 1'b0;
      mem_addr      = '0;
      mem_data_in   = '0;
      dc_wr_ack     = 1'b0;
      fill_data     = '0;
      fill_idx      = '0;
      ic_fill_valid = 1'b0;
      dc_fill_valid = 1'b0;
      ic_done       = 1'b0;
      dc_done       = 1'b0;

      case (state_q)
         ST_WRITE: begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = dc_wr_addr;
            mem_data_in = dc_wr_data;
            dc_wr_ack   = 1'b1;
         end
         ST_ISSUE: begin
            mem_enable = 1'b1;
            mem_addr   = base_q + {{(ADDR_W-IDX_W-1){1'b0}}, issue_cnt, 1'b0};
         end
         default: ;
      endcase

      if (ret_ok) begin
         fill_data = mem_data_out;
         fill_idx  = ret_cnt;
         if (gnt_q == GNT_I) begin
            ic_fill_valid = 1'b1;
            ic_done       = last_return;
         end else begin
            dc_fill_valid = 1'b1;
            dc_done       = last_return;
         end
      end
   end

   // Drain is not counted as busy so the reset state presents a quiet interface;
   // any request raised during drain still stalls through the pending term.
   assign busy = (state_q != ST_IDLE && state_q != ST_DRAIN)
               || ic_req || dc_req || dc_wr_req;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ic_req, dc_req, dc_wr_req;
   logic [15:0] ic_addr, dc_addr, dc_wr_addr, dc_wr_data;
   logic [15:0] mem_data_out;
   logic        mem_data_valid;
   logic [15:0] mem_addr, mem_data_in, fill_data;
   logic        mem_enable, mem_wr;
   logic        ic_fill_valid, dc_fill_valid, ic_done, dc_done, dc_wr_ack, busy;
   logic [2:0]  fill_idx;

   int n_assert = 0;
   int n_fail   = 0;

   // Memory model: read pipeline MEM_LAT deep, plus forced spurious valid.
   logic        vp [4];
   logic [15:0] ap [4];
   logic        inj_valid;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr),
      .dc_req(dc_req), .dc_addr(dc_addr),
      .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
      .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
      .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
      .mem_data_in(mem_data_in), .fill_data(fill_data),
      .ic_fill_valid(ic_fill_valid), .dc_fill_valid(dc_fill_valid),
      .fill_idx(fill_idx), .ic_done(ic_done), .dc_done(dc_done),
      .dc_wr_ack(dc_wr_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; update the memory model at the negedge, then settle.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      mem_data_valid = vp[3] | inj_valid;
      mem_data_out   = vp[3] ? mem_word(ap[3]) : (inj_valid ? 16'hDEAD : 16'h0000);
      for (int i = 3; i > 0; i--) begin
         vp[i] = vp[i-1];
         ap[i] = ap[i-1];
      end
      vp[0] = mem_enable && !mem_wr;
      ap[0] = mem_addr;
      #1;
      chk("excl_valid", 32'($countones({ic_fill_valid, dc_fill_valid, dc_wr_ack})) <= 1, 1);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_en"},   mem_enable, 0);
      chk({tag, "_wr"},   mem_wr, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_din"},  mem_data_in, 0);
      chk({tag, "_fdat"}, fill_data, 0);
      chk({tag, "_icfv"}, ic_fill_valid, 0);
      chk({tag, "_dcfv"}, dc_fill_valid, 0);
      chk({tag, "_idx"},  fill_idx, 0);
      chk({tag, "_icd"},  ic_done, 0);
      chk({tag, "_dcd"},  dc_done, 0);
      chk({tag, "_ack"},  dc_wr_ack, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Full fill granted at the edge ending the current cycle (T0); checks T1..T14.
   // Drops the granted request after the DONE cycle; raises dc_wr_req at wr_at.
   task automatic run_fill(input bit side_d, input logic [15:0] addr, input int wr_at);
      logic [15:0] base;
      logic        rv;
      base = addr & 16'hFFF0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         chk("issue_en", mem_enable, (k <= 8) ? 1 : 0);
         chk("issue_wr", mem_wr, 0);
         if (k <= 8)
            chk("issue_addr", mem_addr, 32'(16'(base + 16'(2 * (k - 1)))));
         rv = (k >= 5 && k <= 12);
         chk("ic_fill_valid", ic_fill_valid, rv && !side_d);
         chk("dc_fill_valid", dc_fill_valid, rv && side_d);
         if (rv) begin
            chk("fill_idx", fill_idx, k - 5);
            chk("fill_data", fill_data, mem_word(16'(base + 16'(2 * (k - 5)))));
         end
         chk("ic_done", ic_done, (k == 12) && !side_d);
         chk("dc_done", dc_done, (k == 12) && side_d);
         chk("dc_wr_ack", dc_wr_ack, 0);
         if (k <= 13)
            chk("busy", busy, 1);
         if (k == wr_at)
            dc_wr_req = 1'b1;
         if (k == 13) begin
            if (side_d) dc_req = 1'b0;
            else        ic_req = 1'b0;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         vp[i] = 1'b0;
         ap[i] = '0;
      end
      inj_valid = 0; mem_data_valid = 0; mem_data_out = 0;
      ic_req = 0; dc_req = 0; dc_wr_req = 0;
      ic_addr = 0; dc_addr = 0; dc_wr_addr = 0; dc_wr_data = 0;
      rst = 1;

      // Reset state
      tick();
      tick();
      chk_quiet("reset");
      rst = 0;
      for (int i = 0; i < 6; i++) tick();
      chk_quiet("drained");

      // Spurious valid in IDLE
      inj_valid = 1;
      tick();
      chk("spur_dcfv", dc_fill_valid, 0);
      chk("spur_icfv", ic_fill_valid, 0);
      chk("spur_idx", fill_idx, 0);
      chk("spur_busy", busy, 0);
      inj_valid = 0;
      tick();

      // Single D fill, misaligned address; index must start at 0
      dc_addr = 16'h1236; dc_req = 1;
      run_fill(1, 16'h1236, 0);

      // Both raised after reset: I first (last_grant = D), then D
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < 5; i++) tick();
      ic_addr = 16'h2004; dc_addr = 16'h345A;
      ic_req = 1; dc_req = 1;
      run_fill(0, 16'h2004, 0);
      run_fill(1, 16'h345A, 0);

      // Store raised during an I fill waits, then beats a pending ic_req
      ic_addr = 16'h4444; ic_req = 1;
      dc_wr_addr = 16'h5556; dc_wr_data = 16'hBEEF;
      run_fill(0, 16'h4444, 6);
      ic_addr = 16'h6002; ic_req = 1;
      tick();
      chk("wr_en", mem_enable, 1);
      chk("wr_wr", mem_wr, 1);
      chk("wr_addr", mem_addr, 16'h5556);
      chk("wr_data", mem_data_in, 16'hBEEF);
      chk("wr_ack", dc_wr_ack, 1);
      chk("wr_icfv", ic_fill_valid, 0);
      dc_wr_req = 0;
      tick();
      chk("post_wr_en", mem_enable, 0);
      chk("post_wr_ack", dc_wr_ack, 0);
      run_fill(0, 16'h6002, 0);

      // Top-of-memory block: FFF0..FFFE, no wrap
      ic_addr = 16'hFFFE; ic_req = 1;
      run_fill(0, 16'hFFFE, 0);

      // Reset at return 3 of a D fill
      dc_addr = 16'h7778; dc_req = 1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("ab_en", mem_enable, 1);
         chk("ab_addr", mem_addr, 32'(16'(16'h7770 + 16'(2 * (k - 1)))));
         chk("ab_dcfv", dc_fill_valid, (k >= 5) ? 1 : 0);
         if (k >= 5)
            chk("ab_idx", fill_idx, k - 5);
      end
      rst = 1; dc_req = 0;
      tick();
      chk_quiet("abort");
      rst = 0;
      for (int k = 10; k <= 14; k++) begin
         tick();
         chk("stale_dcfv", dc_fill_valid, 0);
         chk("stale_icfv", ic_fill_valid, 0);
         chk("stale_done", dc_done, 0);
         chk("stale_en", mem_enable, 0);
         chk("stale_busy", busy, 0);
      end
      dc_addr = 16'h789A; dc_req = 1;
      run_fill(1, 16'h789A, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
